prm_edge_mask_engine: RTL and testbench
=======================================

# prm_edge_mask_engine

Streaming, table-driven PRM edge collision checker. It is the parametrised, sequential successor to the fixed 15-input combinational obstacle-logic checkers. The obstacle truth table lives in a loadable, double-banked bit RAM instead of hard-wired sum-of-products. Interpolated configuration samples along a roadmap edge stream in one per cycle, and the block emits one edge-blocked verdict per edge. It sits between the edge sampler and the roadmap graph builder.

## Interface
- `ADDR_W`, 15, configuration-code bits per sample; each bit is one quantised joint-space variable, bit 0 = variable A.
- `EDGE_ID_W`, 8, edge tag width.
- `CNT_W`, 8, per-edge sample counter width; the counter saturates.
- `BANKS`, 2, number of table banks (≥1).
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `tbl_wr_en`  in  1  table write strobe.
- `tbl_wr_bank`  in  $clog2(BANKS)  bank to write.
- `tbl_wr_addr`  in  ADDR_W  configuration code to write.
- `tbl_wr_data`  in  1  value to store: 1 = configuration collides.
- `cfg_bank`  in  $clog2(BANKS)  bank used for the next edge; latched on that edge's first sample.
- `cfg_early_exit`  in  1  when 1, skip lookups after an edge is already blocked; latched on the first sample.
- `s_valid` / `s_ready`  in / out  1  sample handshake.
- `s_addr`  in  ADDR_W  sample configuration code.
- `s_edge_id`  in  EDGE_ID_W  edge tag; sampled on the first beat only.
- `s_last`  in  1  marks the final sample of the edge.
- `m_valid` / `m_ready`  out / in  1  result handshake.
- `m_edge_id`  out  EDGE_ID_W  tag of the edge being reported.
- `m_mask`  out  1  1 = edge blocked; same polarity as the legacy `edge_mask`.
- `m_count`  out  CNT_W  samples accepted for the edge; saturates at all-ones.
- `m_lookups`  out  CNT_W  table reads actually performed for the edge; saturates.

## Operation
- A beat is accepted when `s_valid & s_ready`. The first beat after reset, or after an `s_last` beat, opens a new edge. On that beat, `s_edge_id`, `cfg_bank` and `cfg_early_exit` are latched.
- Stage 0 accepts the beat and issues a synchronous RAM read of `{bank, s_addr}`. If early exit is latched and the edge's accumulated mask, including in-flight hits, is already 1, the read is suppressed and the sample is still counted.
- Stage 1 receives read data one cycle later. The edge mask becomes `mask | data`, gated by a read-valid flag. The count and lookup counters increment with saturation.
- When a beat carrying `s_last` reaches stage 1, the result is loaded into a one-entry output register, `m_valid` rises, and the accumulators clear for the next edge. A new edge's first beat may be in stage 0 in the same cycle.
- A single-beat edge (first beat and `s_last` together) is legal.
- Output register: `m_*` hold stable while `m_valid & !m_ready`.
- Back-pressure: `s_ready = !(out_full & !m_ready) & !(stage1_last & out_full & !m_ready)`. It is registered-safe: no beat carrying `s_last` is ever accepted unless its result slot is guaranteed free.
- Table RAM:
  - `BANKS × 2^ADDR_W × 1` bits, one write port and one read port, read-first.
  - A write and a read to the same address in the same cycle return the old value.
  - Writes to a bank other than the one in use proceed freely. This is the intended reload path: load bank k while edges check against bank j.
- RAM contents are not reset. The bench must load the table before checking edges.

## Timing
- Reset values: `m_valid=0`, `m_mask=0`, `m_edge_id=0`, `m_count=0`, `m_lookups=0`, `s_ready=1` on the first cycle after `RST` deasserts. All pipeline valids and accumulators are 0.
- `RST` asserted mid-edge discards the in-flight edge and any unread result; no partial result is emitted.
- Latency: with `m_ready=1`, `m_valid` asserts 2 cycles after the `s_last` beat is accepted.
- Throughput: one sample per cycle sustained. Back-to-back edges have no bubble.
- Counter saturation: after 2^CNT_W−1, further beats leave `m_count` unchanged; `m_mask` remains correct.

## Structure
- Package `prm_chk_pkg`: `ADDR_W` default, a `edge_result_t` struct (`edge_id`, `mask`, `count`, `lookups`), and a saturating-increment function.
- Sub-module `prm_tbl_ram`: banked 1-bit read-first RAM, parameters `ADDR_W` and `BANKS`.
- The top level holds the stage-0/stage-1 pipeline and the output register.

## Test plan
- **Reset and idle:** hold `RST` for 3 cycles, then release → `m_valid=0`, `s_ready=1`, all outputs 0.
- **Clear edge:** load bank 0 with a single 1 at 0x1234; stream edge id 5 with samples 0x0001, 0x0002, 0x0003 (last) → `m_mask=0`, `m_count=3`, `m_lookups=3`, `m_valid` exactly 2 cycles after the last beat.
- **Blocked edge, early exit:** same table, `cfg_early_exit=1`; samples 0x1234, 0x0001, 0x0002 (last) → `m_mask=1`, `m_count=3`, `m_lookups=1`.
- **Bank swap during load:** write 0x0001=1 in bank 1 while edge id 7 runs on bank 0 with sample 0x0001 → edge 7 reports `m_mask=0`; the next edge on bank 1 with 0x0001 reports `m_mask=1`.
- **Back-pressure:** hold `m_ready=0` and stream three single-beat edges → the first result is held stable, `s_ready` drops, and after `m_ready=1` all three results arrive in order with no loss.
- **Mid-edge reset:** assert `RST` after 2 of 4 beats → no result emitted; the next edge reports `m_count` from 1.

Source files
------------

// File: rtl/prm_edge_mask_engine_pkg.sv
// Shared definitions for the PRM edge collision checker.
// Contents:
//   DEF_*          default widths and bank count used by the engine and its bus
//   edge_result_t  one reported edge verdict (edge_id, mask, count, lookups)
//   sat_inc        increment that sticks at a caller-supplied maximum
package prm_chk_pkg;

    localparam int DEF_ADDR_W    = 15;
    localparam int DEF_EDGE_ID_W = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_BANKS     = 2;

    typedef struct packed {
        logic [DEF_EDGE_ID_W-1:0] edge_id;
        logic                     mask;
        logic [DEF_CNT_W-1:0]     count;
        logic [DEF_CNT_W-1:0]     lookups;
    } edge_result_t;

    // Counters report "at least max" once they reach the top instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        return (value >= max_value) ? value : value + 1;
    endfunction

endpackage

// File: rtl/prm_edge_mask_engine_if.sv
// Bus bundle for prm_edge_mask_engine.
// Groups:
//   tbl_wr_*        table load port (bank, configuration code, collide bit)
//   cfg_*           per-edge settings, taken from an edge's first sample
//   s_*             sample stream in (valid/ready, addr, edge_id, last)
//   m_*             edge verdict out (valid/ready, edge_id, mask, count, lookups)
// Modports: master = sampler/builder side, slave = checker engine.
interface prm_edge_mask_engine_if #(
    parameter int ADDR_W    = prm_chk_pkg::DEF_ADDR_W,
    parameter int EDGE_ID_W = prm_chk_pkg::DEF_EDGE_ID_W,
    parameter int CNT_W     = prm_chk_pkg::DEF_CNT_W,
    parameter int BANKS     = prm_chk_pkg::DEF_BANKS
);
    import prm_chk_pkg::*;

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                 tbl_wr_en;
    logic [BANK_W-1:0]    tbl_wr_bank;
    logic [ADDR_W-1:0]    tbl_wr_addr;
    logic                 tbl_wr_data;

    logic [BANK_W-1:0]    cfg_bank;
    logic                 cfg_early_exit;

    logic                 s_valid;
    logic                 s_ready;
    logic [ADDR_W-1:0]    s_addr;
    logic [EDGE_ID_W-1:0] s_edge_id;
    logic                 s_last;

    logic                 m_valid;
    logic                 m_ready;
    logic [EDGE_ID_W-1:0] m_edge_id;
    logic                 m_mask;
    logic [CNT_W-1:0]     m_count;
    logic [CNT_W-1:0]     m_lookups;

    modport master (
        output tbl_wr_en, tbl_wr_bank, tbl_wr_addr, tbl_wr_data,
        output cfg_bank, cfg_early_exit,
        output s_valid, s_addr, s_edge_id, s_last,
        input  s_ready,
        input  m_valid, m_edge_id, m_mask, m_count, m_lookups,
        output m_ready
    );

    modport slave (
        input  tbl_wr_en, tbl_wr_bank, tbl_wr_addr, tbl_wr_data,
        input  cfg_bank, cfg_early_exit,
        input  s_valid, s_addr, s_edge_id, s_last,
        output s_ready,
        output m_valid, m_edge_id, m_mask, m_count, m_lookups,
        input  m_ready
    );

endinterface

// File: rtl/prm_edge_mask_engine_tbl_ram.sv
// prm_tbl_ram: banked 1-bit obstacle table, one write port and one read port.
// Reads are registered and read-first: a same-cycle write to the address
// being read returns the previous contents. Contents are not reset.
// Ports:
//   clk                          rising-edge clock
//   wr_en/wr_bank/wr_addr/wr_data  table write (1 = configuration collides)
//   rd_en/rd_bank/rd_addr        read request; rd_data valid the next cycle
//   rd_data                      holds its value while rd_en is low
module prm_tbl_ram
    import prm_chk_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANKS  = DEF_BANKS,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic mem [BANKS][DEPTH];

    // Both ports update on the same edge; the non-blocking read of mem sees
    // the pre-write value, which gives read-first behaviour. Writes naming a
    // bank that does not exist are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_bank <= BANK_W'(BANKS - 1))) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine: streaming, table-driven PRM edge collision checker.
// Samples of a roadmap edge arrive one per cycle; each is looked up in the
// banked obstacle table and OR-ed into the edge mask. One verdict per edge
// is produced through a one-entry output register.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (table contents are kept)
//   bus   prm_edge_mask_engine_if slave: table load, cfg, s_* stream in,
//         m_* verdict out
// Pipeline: stage 0 accepts a beat and issues the table read; stage 1
// folds the read data into the per-edge accumulators and, on the last beat,
// loads the output register.
module prm_edge_mask_engine
    import prm_chk_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int EDGE_ID_W = DEF_EDGE_ID_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BANKS     = DEF_BANKS
) (
    input  logic                  clk,
    input  logic                  rst,
    prm_edge_mask_engine_if.slave bus
);

    localparam int          BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    // Edge bookkeeping in stage 0
    logic                 edge_open;
    logic [EDGE_ID_W-1:0] edge_id_lat;
    logic [BANK_W-1:0]    bank_lat;
    logic                 early_lat;

    // Stage 1 beat and per-edge accumulators
    logic                 s1_valid;
    logic                 s1_last;
    logic                 s1_rd_valid;
    logic                 mask_acc;
    logic [CNT_W-1:0]     count_acc;
    logic [CNT_W-1:0]     lookups_acc;

    // Output register
    logic                 out_valid;
    logic [EDGE_ID_W-1:0] out_edge_id;
    logic                 out_mask;
    logic [CNT_W-1:0]     out_count;
    logic [CNT_W-1:0]     out_lookups;

    logic                 s_ready_int;
    logic                 s_fire;
    logic                 first_beat;
    logic [BANK_W-1:0]    rd_bank;
    logic                 early_eff;
    logic                 rd_en;
    logic                 rd_data;
    logic                 hit;
    logic                 mask_now;
    logic                 blocked_now;
    logic                 s1_stall;
    logic                 out_load;
    logic [CNT_W-1:0]     count_next;
    logic [CNT_W-1:0]     lookups_next;

    prm_tbl_ram #(
        .ADDR_W (ADDR_W),
        .BANKS  (BANKS)
    ) u_tbl_ram (
        .clk     (clk),
        .wr_en   (bus.tbl_wr_en),
        .wr_bank (bus.tbl_wr_bank),
        .wr_addr (bus.tbl_wr_addr),
        .wr_data (bus.tbl_wr_data),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (bus.s_addr),
        .rd_data (rd_data)
    );

    // A full output slot that is not being drained blocks new beats. That
    // also keeps a stalled last beat in stage 1 from being overrun, so a beat
    // carrying s_last is only accepted when its result has somewhere to go.
    assign s_ready_int = !(out_valid & !bus.m_ready)
                       & !(s1_valid & s1_last & out_valid & !bus.m_ready);
    assign s_fire      = bus.s_valid & s_ready_int;
    assign first_beat  = !edge_open;

    // The first beat uses the live cfg inputs; later beats use the latched copy.
    assign rd_bank     = first_beat ? bus.cfg_bank       : bank_lat;
    assign early_eff   = first_beat ? bus.cfg_early_exit : early_lat;

    // Stage 1 read result, ignored when the read was skipped.
    assign hit         = s1_valid & s1_rd_valid & rd_data;
    assign mask_now    = mask_acc | hit;

    // On a first beat, stage 1 and the accumulators still belong to the
    // previous edge, so they must not suppress the new edge's read.
    assign blocked_now = !first_beat & mask_now;
    assign rd_en       = s_fire & !(early_eff & blocked_now);

    assign s1_stall     = s1_valid & s1_last & out_valid & !bus.m_ready;
    assign out_load     = s1_valid & s1_last & !s1_stall;
    assign count_next   = CNT_W'(sat_inc(32'(count_acc), CNT_MAX));
    assign lookups_next = s1_rd_valid ? CNT_W'(sat_inc(32'(lookups_acc), CNT_MAX))
                                      : lookups_acc;

    // Stage 0: track whether an edge is open and latch its per-edge settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_open   <= 1'b0;
            edge_id_lat <= '0;
            bank_lat    <= '0;
            early_lat   <= 1'b0;
        end else if (s_fire) begin
            if (first_beat) begin
                edge_id_lat <= bus.s_edge_id;
                bank_lat    <= bus.cfg_bank;
                early_lat   <= bus.cfg_early_exit;
            end
            edge_open <= !bus.s_last;
        end
    end

    // Stage 1: carry the beat forward and accumulate; a last beat hands its
    // totals to the output register and leaves the accumulators clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_rd_valid <= 1'b0;
            mask_acc    <= 1'b0;
            count_acc   <= '0;
            lookups_acc <= '0;
        end else if (!s1_stall) begin
            s1_valid    <= s_fire;
            s1_last     <= s_fire & bus.s_last;
            s1_rd_valid <= rd_en;
            if (s1_valid) begin
                if (s1_last) begin
                    mask_acc    <= 1'b0;
                    count_acc   <= '0;
                    lookups_acc <= '0;
                end else begin
                    mask_acc    <= mask_now;
                    count_acc   <= count_next;
                    lookups_acc <= lookups_next;
                end
            end
        end
    end

    // Output register: reload whenever a finished edge arrives (the old entry
    // is either empty or leaving this cycle), otherwise drain on m_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_edge_id <= '0;
            out_mask    <= 1'b0;
            out_count   <= '0;
            out_lookups <= '0;
        end else if (out_load) begin
            out_valid   <= 1'b1;
            out_edge_id <= edge_id_lat;
            out_mask    <= mask_now;
            out_count   <= count_next;
            out_lookups <= lookups_next;
        end else if (bus.m_ready) begin
            out_valid   <= 1'b0;
        end
    end

    assign bus.s_ready   = s_ready_int;
    assign bus.m_valid   = out_valid;
    assign bus.m_edge_id = out_edge_id;
    assign bus.m_mask    = out_mask;
    assign bus.m_count   = out_count;
    assign bus.m_lookups = out_lookups;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Self-checking bench for prm_edge_mask_engine: directed scenarios plus a
// randomized run scored against a per-edge reference model.
module tb_prm_edge_mask_engine;
    import prm_chk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    bit   rand_ready = 1'b0;

    bit           ref_tbl [2][1 << 15];
    edge_result_t got_q[$];
    int           got_cyc_q[$];
    edge_result_t exp_q[$];
    edge_result_t mon_r;
    logic [14:0]  pool [12];

    prm_edge_mask_engine_if #(.ADDR_W(15), .EDGE_ID_W(8), .CNT_W(8), .BANKS(2)) bus ();

    prm_edge_mask_engine #(.ADDR_W(15), .EDGE_ID_W(8), .CNT_W(8), .BANKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every completed result handshake (m_valid & m_ready at the next edge)
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            mon_r.edge_id = bus.m_edge_id;
            mon_r.mask    = bus.m_mask;
            mon_r.count   = bus.m_count;
            mon_r.lookups = bus.m_lookups;
            got_q.push_back(mon_r);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: mask is the OR of the bank's bits over the edge; with early
    // exit the table is read up to and including the first colliding sample.
    function automatic edge_result_t model_edge(input logic [7:0] id, input logic [14:0] addrs[$],
                                                input int bank, input bit early);
        edge_result_t r;
        int n = addrs.size();
        int first_hit = -1;
        int lk;
        for (int i = 0; i < n; i++) begin
            if (ref_tbl[bank][addrs[i]] && first_hit < 0) first_hit = i;
        end
        lk = (early && first_hit >= 0) ? first_hit + 1 : n;
        r.edge_id = id;
        r.mask    = (first_hit >= 0);
        r.count   = (n > 255) ? 8'd255 : 8'(n);
        r.lookups = (lk > 255) ? 8'd255 : 8'(lk);
        return r;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input int bank, input logic [14:0] addr, input bit data);
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_bank = bank[0];
        bus.tbl_wr_addr = addr;
        bus.tbl_wr_data = data;
        sync();
        bus.tbl_wr_en   = 1'b0;
        ref_tbl[bank][addr] = data;
    endtask

    task automatic send_beat(input logic [14:0] addr, input logic [7:0] id, input logic last,
                             input logic bank, input logic early);
        int guard = 0;
        bus.s_valid        = 1'b1;
        bus.s_addr         = addr;
        bus.s_edge_id      = id;
        bus.s_last         = last;
        bus.cfg_bank       = bank;
        bus.cfg_early_exit = early;
        @(negedge clk);
        while (!bus.s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL s_ready_timeout got s_ready=0 required 1 within 200 cycles");
        end
        last_acc_cyc = cyc;
        sync();
        bus.s_valid = 1'b0;
    endtask

    // Later beats carry random cfg and id values, which the engine must ignore.
    task automatic send_edge(input logic [7:0] id, input logic [14:0] addrs[$],
                             input int bank, input bit early);
        for (int i = 0; i < addrs.size(); i++) begin
            if (i == 0) send_beat(addrs[i], id, (addrs.size() == 1), bank[0], early);
            else send_beat(addrs[i], 8'($urandom), (i == addrs.size() - 1),
                           1'($urandom), 1'($urandom));
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        int waited = 0;
        while (got_q.size() < n && waited < budget) begin
            @(posedge clk);
            waited++;
        end
        #1;
        if (got_q.size() < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout got %0d results required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.tbl_wr_en = 0; bus.tbl_wr_bank = 0; bus.tbl_wr_addr = 0; bus.tbl_wr_data = 0;
        bus.cfg_bank = 0; bus.cfg_early_exit = 0; bus.s_valid = 0; bus.s_addr = 0;
        bus.s_edge_id = 0; bus.s_last = 0; bus.m_ready = 1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %0b required 0", bus.m_valid); end
        if (bus.s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %0b required 1", bus.s_ready); end
        if (bus.m_mask !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_mask got %0b required 0", bus.m_mask); end
        if (bus.m_edge_id !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_edge_id got %0d required 0", bus.m_edge_id); end
        if (bus.m_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_count got %0d required 0", bus.m_count); end
        if (bus.m_lookups !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_lookups got %0d required 0", bus.m_lookups); end
        sync();
    endtask

    task automatic test_clear_edge();
        edge_result_t got;
        edge_result_t exp = '{edge_id: 8'd5, mask: 1'b0, count: 8'd3, lookups: 8'd3};
        int lat;
        load_table(0, 15'h1234, 1'b1);
        load_table(0, 15'h0001, 1'b0);
        load_table(0, 15'h0002, 1'b0);
        load_table(0, 15'h0003, 1'b0);
        load_table(1, 15'h0001, 1'b0);
        load_table(1, 15'h1234, 1'b0);
        send_edge(8'd5, '{15'h0001, 15'h0002, 15'h0003}, 0, 1'b0);
        wait_results(1, 50);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            lat = got_cyc_q.pop_front() - last_acc_cyc;
            checks += 2;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL clear_edge got id=%0d mask=%0b cnt=%0d lk=%0d required id=%0d mask=%0b cnt=%0d lk=%0d",
                         got.edge_id, got.mask, got.count, got.lookups, exp.edge_id, exp.mask, exp.count, exp.lookups);
            end
            if (lat !== 2) begin errors++; $display("[TB] FAIL clear_edge_latency got %0d cycles required 2", lat); end
        end
    endtask

    task automatic test_early_exit();
        edge_result_t got;
        edge_result_t exp = '{edge_id: 8'd6, mask: 1'b1, count: 8'd3, lookups: 8'd1};
        send_edge(8'd6, '{15'h1234, 15'h0001, 15'h0002}, 0, 1'b1);
        wait_results(1, 50);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            void'(got_cyc_q.pop_front());
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL early_exit got mask=%0b cnt=%0d lk=%0d required mask=%0b cnt=%0d lk=%0d",
                         got.mask, got.count, got.lookups, exp.mask, exp.count, exp.lookups);
            end
        end
    endtask

    task automatic test_bank_swap();
        edge_result_t got;
        edge_result_t exp [2];
        exp[0] = '{edge_id: 8'd7, mask: 1'b0, count: 8'd1, lookups: 8'd1};
        exp[1] = '{edge_id: 8'd8, mask: 1'b1, count: 8'd1, lookups: 8'd1};
        bus.tbl_wr_en   = 1'b1;
        bus.tbl_wr_bank = 1'b1;
        bus.tbl_wr_addr = 15'h0001;
        bus.tbl_wr_data = 1'b1;
        send_beat(15'h0001, 8'd7, 1'b1, 1'b0, 1'b0);
        bus.tbl_wr_en = 1'b0;
        ref_tbl[1][15'h0001] = 1'b1;
        send_beat(15'h0001, 8'd8, 1'b1, 1'b1, 1'b0);
        wait_results(2, 50);
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                void'(got_cyc_q.pop_front());
                checks++;
                if (got !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL bank_swap[%0d] got id=%0d mask=%0b required id=%0d mask=%0b",
                             i, got.edge_id, got.mask, exp[i].edge_id, exp[i].mask);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        edge_result_t got;
        edge_result_t exp [3];
        exp[0] = '{edge_id: 8'd30, mask: 1'b1, count: 8'd1, lookups: 8'd1};
        exp[1] = '{edge_id: 8'd31, mask: 1'b0, count: 8'd1, lookups: 8'd1};
        exp[2] = '{edge_id: 8'd32, mask: 1'b0, count: 8'd1, lookups: 8'd1};
        bus.m_ready = 1'b0;
        fork
            begin
                send_beat(15'h1234, 8'd30, 1'b1, 1'b0, 1'b0);
                send_beat(15'h0001, 8'd31, 1'b1, 1'b0, 1'b0);
                send_beat(15'h0003, 8'd32, 1'b1, 1'b0, 1'b0);
            end
        join_none
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.m_valid, bus.m_edge_id, bus.m_mask} !== {1'b1, 8'd30, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bp_hold got valid=%0b id=%0d mask=%0b required valid=1 id=30 mask=1",
                         bus.m_valid, bus.m_edge_id, bus.m_mask);
            end
        end
        checks++;
        if (bus.s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready got %0b required 0", bus.s_ready); end
        sync();
        bus.m_ready = 1'b1;
        wait fork;
        wait_results(3, 50);
        for (int i = 0; i < 3; i++) begin
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                void'(got_cyc_q.pop_front());
                checks++;
                if (got !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL bp_order[%0d] got id=%0d mask=%0b cnt=%0d required id=%0d mask=%0b cnt=%0d",
                             i, got.edge_id, got.mask, got.count, exp[i].edge_id, exp[i].mask, exp[i].count);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        edge_result_t got;
        edge_result_t exp = '{edge_id: 8'd21, mask: 1'b0, count: 8'd1, lookups: 8'd1};
        send_beat(15'h1234, 8'd20, 1'b0, 1'b0, 1'b0);
        send_beat(15'h0001, 8'd20, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks += 2;
        if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL mid_reset_results got %0d results required 0", got_q.size()); end
        if (bus.m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_m_valid got %0b required 0", bus.m_valid); end
        sync();
        send_beat(15'h0002, 8'd21, 1'b1, 1'b0, 1'b0);
        wait_results(1, 50);
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
            void'(got_cyc_q.pop_front());
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_next got id=%0d cnt=%0d lk=%0d required id=21 cnt=1 lk=1",
                         got.edge_id, got.count, got.lookups);
            end
        end
    endtask

    task automatic test_saturation();
        edge_result_t got;
        edge_result_t exp [2];
        logic [14:0] a0[$];
        logic [14:0] a1[$];
        exp[0] = '{edge_id: 8'd40, mask: 1'b1, count: 8'd255, lookups: 8'd255};
        exp[1] = '{edge_id: 8'd41, mask: 1'b1, count: 8'd255, lookups: 8'd1};
        for (int i = 0; i < 300; i++) begin
            a0.push_back((i == 280) ? 15'h1234 : 15'h0002);
            a1.push_back((i == 0) ? 15'h1234 : 15'h0002);
        end
        send_edge(8'd40, a0, 0, 1'b0);
        send_edge(8'd41, a1, 0, 1'b1);
        wait_results(2, 50);
        for (int i = 0; i < 2; i++) begin
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                void'(got_cyc_q.pop_front());
                checks++;
                if (got !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL saturation[%0d] got mask=%0b cnt=%0d lk=%0d required mask=%0b cnt=%0d lk=%0d",
                             i, got.mask, got.count, got.lookups, exp[i].mask, exp[i].count, exp[i].lookups);
                end
            end
        end
    endtask

    task automatic test_random();
        edge_result_t got;
        edge_result_t exp;
        logic [14:0] addrs[$];
        logic [7:0]  id;
        int          bank;
        bit          early;
        for (int i = 0; i < 12; i++) begin
            pool[i] = 15'(16'h4000 + i * 37);
            load_table(0, pool[i], 1'($urandom));
            load_table(1, pool[i], 1'($urandom));
        end
        rand_ready = 1'b1;
        for (int e = 0; e < 40; e++) begin
            addrs.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) addrs.push_back(pool[$urandom_range(0, 11)]);
            id    = 8'($urandom);
            bank  = $urandom_range(0, 1);
            early = 1'($urandom);
            exp_q.push_back(model_edge(id, addrs, bank, early));
            send_edge(id, addrs, bank, early);
            if ($urandom_range(0, 3) == 0) sync();
        end
        wait_results(40, 2000);
        rand_ready = 1'b0;
        sync();
        bus.m_ready = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (got_q.size() > 0) begin
                got = got_q.pop_front();
                void'(got_cyc_q.pop_front());
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL random_edge got id=%0d mask=%0b cnt=%0d lk=%0d required id=%0d mask=%0b cnt=%0d lk=%0d",
                             got.edge_id, got.mask, got.count, got.lookups, exp.edge_id, exp.mask, exp.count, exp.lookups);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_edge();
        test_early_exit();
        test_bank_swap();
        test_back_pressure();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
